// File: rtl/icache_nway.sv
// -----------------------------------------------------------------------------
// icache_nway
//
// Set-associative instruction cache with multi-word blocks, placed between the
// fetch stage and the memory arbiter. A lookup that hits is answered in the
// same cycle. A miss fetches the whole block in word order. The block is then
// installed into an invalid way if one exists, or into the round-robin victim
// of the set. A flush request clears one set per cycle.
//
// Ports
//   CLK, nRST    : clock (rising edge) and asynchronous active-low reset
//   imemREN      : fetch read request
//   imemaddr     : fetch byte address (byte offset ignored)
//   ihit         : request served this cycle (combinational)
//   imemload     : instruction word when ihit=1, otherwise 0
//   iflush       : pulse, invalidate the entire cache
//   iflush_done  : pulse on the cycle the last set is cleared
//   iREN, iaddr  : memory read request and word address during a fill
//   iload, iwait : memory read data and busy flag (data valid when iwait=0)
// -----------------------------------------------------------------------------
module icache_nway #(
    parameter int WORD_W    = 32,
    parameter int NSETS     = 16,
    parameter int NWAYS     = 2,
    parameter int BLK_WORDS = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    input  logic              iflush,
    output logic              iflush_done,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic [WORD_W-1:0] iload,
    input  logic              iwait
);

    localparam int BYT_W  = $clog2(WORD_W / 8);
    localparam int IDX_W  = $clog2(NSETS);
    localparam int BLK_W  = $clog2(BLK_WORDS);
    localparam int TAG_W  = WORD_W - IDX_W - BLK_W - BYT_W;
    localparam int BOFF_W = (BLK_W > 0) ? BLK_W : 1;
    localparam int WAY_W  = (NWAYS > 1) ? $clog2(NWAYS) : 1;
    // One counter serves both as the fill word index and as the flush set index.
    localparam int CNT_W  = (IDX_W > BLK_W) ? IDX_W : BLK_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    // Control state (reset)
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [NWAYS-1:0] valid_q [NSETS];
    logic [NWAYS-1:0] valid_d [NSETS];
    logic [WAY_W-1:0] rr_q [NSETS];
    logic [WAY_W-1:0] rr_d [NSETS];

    // Datapath state (no reset)
    logic [TAG_W-1:0]  ftag_q, ftag_d;
    logic [IDX_W-1:0]  fidx_q, fidx_d;
    logic [WORD_W-1:0] lbuf_q [BLK_WORDS];
    logic [TAG_W-1:0]  tag_mem [NSETS][NWAYS];
    logic [WORD_W-1:0] data_mem [NSETS][NWAYS][BLK_WORDS];

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [BOFF_W-1:0] req_boff;
    logic [NWAYS-1:0]  match;
    logic [BOFF_W-1:0] fill_word;
    logic [IDX_W-1:0]  flush_idx;
    logic [WAY_W-1:0]  victim;
    logic              victim_free;
    logic              beat_acc;
    logic              fill_last;

    assign req_tag   = TAG_W'(imemaddr >> (WORD_W - TAG_W));
    assign req_idx   = IDX_W'(imemaddr >> (BLK_W + BYT_W));
    assign req_boff  = (BLK_W > 0) ? BOFF_W'(imemaddr >> BYT_W) : '0;
    assign fill_word = BOFF_W'(cnt_q);
    assign flush_idx = cnt_q[IDX_W-1:0];

    assign beat_acc  = (state_q == S_FILL) && !iwait;
    assign fill_last = beat_acc && (cnt_q == CNT_W'(BLK_WORDS - 1));

    always_comb begin
        match = '0;
        for (int w = 0; w < NWAYS; w++) begin
            match[w] = valid_q[req_idx][w] && (tag_mem[req_idx][w] == req_tag);
        end
    end

    // A pending flush request wins over serving a hit in the same cycle.
    always_comb begin
        ihit     = (state_q == S_IDLE) && imemREN && !iflush && (|match);
        imemload = '0;
        if (ihit) begin
            for (int w = 0; w < NWAYS; w++) begin
                if (match[w]) begin
                    imemload = imemload | data_mem[req_idx][w][req_boff];
                end
            end
        end
    end

    always_comb begin
        iREN        = (state_q == S_FILL);
        iaddr       = '0;
        if (iREN) begin
            iaddr = (WORD_W'(ftag_q) << (WORD_W - TAG_W))
                  | (WORD_W'(fidx_q) << (BLK_W + BYT_W))
                  | ((BLK_W > 0) ? (WORD_W'(fill_word) << BYT_W) : '0);
        end
        iflush_done = (state_q == S_FLUSH) && (cnt_q == CNT_W'(NSETS - 1));
    end

    // Victim: lowest-index invalid way, otherwise the set's round-robin pointer.
    always_comb begin
        victim      = rr_q[fidx_q];
        victim_free = 1'b0;
        for (int w = 0; w < NWAYS; w++) begin
            if (!victim_free && !valid_q[fidx_q][w]) begin
                victim      = WAY_W'(w);
                victim_free = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ftag_d  = ftag_q;
        fidx_d  = fidx_q;
        valid_d = valid_q;
        rr_d    = rr_q;
        case (state_q)
            S_IDLE: begin
                if (iflush) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                end else if (imemREN && !(|match)) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                    ftag_d  = req_tag;
                    fidx_d  = req_idx;
                end
            end
            S_FILL: begin
                if (iflush) begin
                    pend_d = 1'b1;
                end
                if (fill_last) begin
                    valid_d[fidx_q][victim] = 1'b1;
                    if (NWAYS > 1 && !victim_free) begin
                        rr_d[fidx_q] = rr_q[fidx_q] + 1'b1;
                    end
                    cnt_d = '0;
                    // A flush that arrived during the fill runs once the line is in.
                    if (pend_q || iflush) begin
                        state_d = S_FLUSH;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (beat_acc) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FLUSH: begin
                valid_d[flush_idx] = '0;
                rr_d[flush_idx]    = '0;
                if (cnt_q == CNT_W'(NSETS - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            for (int s = 0; s < NSETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            rr_q    <= rr_d;
        end
    end

    // Arrays and fill bookkeeping carry no reset; a reset mid-fill drops the
    // state to IDLE, so the partial line is never written.
    always_ff @(posedge CLK) begin
        ftag_q <= ftag_d;
        fidx_q <= fidx_d;
        if (beat_acc) begin
            lbuf_q[fill_word] <= iload;
        end
        if (fill_last) begin
            tag_mem[fidx_q][victim] <= ftag_q;
            for (int k = 0; k < BLK_WORDS; k++) begin
                data_mem[fidx_q][victim][k] <= (k == BLK_WORDS - 1) ? iload : lbuf_q[k];
            end
        end
    end

    // A tag may live in at most one way of a set.
    always_ff @(posedge CLK) begin
        if (nRST && (state_q == S_IDLE) && imemREN) begin
            assert ($onehot0(match));
        end
    end

endmodule

// File: tb/tb_icache_nway.sv
// -----------------------------------------------------------------------------
// tb_icache_nway
//
// Self-checking bench for icache_nway (16 sets, 2 ways, 2-word blocks).
// Memory returns word(a) = a ^ 32'hC0DE0000. A reference model keeps, per set,
// which block numbers are resident plus a round-robin pointer, and tracks fill
// and flush progress as plain counters.
// -----------------------------------------------------------------------------
module tb_icache_nway;

    localparam int WORD_W    = 32;
    localparam int NSETS     = 16;
    localparam int NWAYS     = 2;
    localparam int BLK_WORDS = 2;
    localparam int BLK_BYTES = BLK_WORDS * 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iflush = 1'b0;
    logic        iflush_done;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload = '0;
    logic        iwait = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model
    bit          m_valid [NSETS][NWAYS];
    int unsigned m_blk   [NSETS][NWAYS];
    int          m_rr    [NSETS];
    int          fill_beat = -1;
    int          flush_set = -1;
    bit          pend = 1'b0;
    logic [31:0] fill_base = '0;

    // Last sampled DUT outputs
    logic        obs_hit, obs_ren, obs_done;
    logic [31:0] obs_load, obs_addr;

    icache_nway #(
        .WORD_W(WORD_W), .NSETS(NSETS), .NWAYS(NWAYS), .BLK_WORDS(BLK_WORDS)
    ) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iflush(iflush),
        .iflush_done(iflush_done), .iREN(iREN), .iaddr(iaddr),
        .iload(iload), .iwait(iwait)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a / BLK_BYTES) % NSETS);
    endfunction

    function automatic int lookup(input logic [31:0] a);
        int s = set_of(a);
        for (int w = 0; w < NWAYS; w++) begin
            if (m_valid[s][w] && (m_blk[s][w] == a / BLK_BYTES)) return w;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NSETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < NWAYS; w++) m_valid[s][w] = 1'b0;
        end
        fill_beat = -1;
        flush_set = -1;
        pend      = 1'b0;
    endtask

    task automatic install();
        int s = set_of(fill_base);
        int v = -1;
        for (int w = 0; w < NWAYS; w++) begin
            if (!m_valid[s][w] && v < 0) v = w;
        end
        if (v < 0) begin
            v = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % NWAYS;
        end
        m_valid[s][v] = 1'b1;
        m_blk[s][v]   = fill_base / BLK_BYTES;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, answer memory, compare to model, advance model.
    task automatic cycle(input bit ren, input logic [31:0] a, input bit fl, input bit wt);
        bit          idle, e_hit, e_ren, e_done;
        logic [31:0] e_load, e_addr;
        @(negedge CLK);
        imemREN  = ren;
        imemaddr = a;
        iflush   = fl;
        iwait    = wt;
        #1;
        iload = mem(iaddr);
        #1;
        idle   = (fill_beat < 0) && (flush_set < 0);
        e_hit  = idle && ren && !fl && (lookup(a) >= 0);
        e_load = e_hit ? mem(a & ~32'd3) : 32'd0;
        e_ren  = (fill_beat >= 0);
        e_addr = e_ren ? (fill_base + 32'(fill_beat * 4)) : 32'd0;
        e_done = (flush_set == NSETS - 1);
        chk("ihit", 32'(ihit), 32'(e_hit));
        chk("imemload", imemload, e_load);
        chk("iREN", 32'(iREN), 32'(e_ren));
        chk("iaddr", iaddr, e_addr);
        chk("iflush_done", 32'(iflush_done), 32'(e_done));
        obs_hit  = ihit;
        obs_load = imemload;
        obs_ren  = iREN;
        obs_addr = iaddr;
        obs_done = iflush_done;
        if (idle) begin
            if (fl) begin
                flush_set = 0;
            end else if (ren && !e_hit) begin
                fill_beat = 0;
                fill_base = a & ~32'(BLK_BYTES - 1);
            end
        end else if (fill_beat >= 0) begin
            if (fl) pend = 1'b1;
            if (!wt) begin
                fill_beat++;
                if (fill_beat == BLK_WORDS) begin
                    install();
                    fill_beat = -1;
                    if (pend) begin
                        pend      = 1'b0;
                        flush_set = 0;
                    end
                end
            end
        end else begin
            for (int w = 0; w < NWAYS; w++) m_valid[flush_set][w] = 1'b0;
            m_rr[flush_set] = 0;
            flush_set++;
            if (flush_set == NSETS) flush_set = -1;
        end
    endtask

    task automatic fill_to_hit(input logic [31:0] a);
        int n = 0;
        cycle(1'b1, a, 1'b0, ($urandom_range(0, 2) == 0));
        n++;
        while (!obs_hit && n < 40) begin
            cycle(1'b1, a, 1'b0, ($urandom_range(0, 2) == 0));
            n++;
        end
        chk("fill_to_hit", 32'(obs_hit), 32'd1);
    endtask

    task automatic count_flush(output int n);
        n = 0;
        obs_done = 1'b0;
        while (!obs_done && n < 40) begin
            cycle(1'b0, 32'd0, 1'b0, 1'b0);
            n++;
        end
    endtask

    // Reset pulse placed mid-cycle; outputs must drop without a clock edge.
    task automatic do_reset_mid();
        @(negedge CLK);
        #1;
        nRST    = 1'b0;
        imemREN = 1'b0;
        iflush  = 1'b0;
        #1;
        chk("rst_mid iREN", 32'(iREN), 32'd0);
        chk("rst_mid iaddr", iaddr, 32'd0);
        chk("rst_mid ihit", 32'(ihit), 32'd0);
        chk("rst_mid iflush_done", 32'(iflush_done), 32'd0);
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        int n;
        logic [31:0] a;
        model_reset();

        // Reset values, with a request present during reset
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        #3;
        chk("reset ihit", 32'(ihit), 32'd0);
        chk("reset iREN", 32'(iREN), 32'd0);
        chk("reset iaddr", iaddr, 32'd0);
        chk("reset iflush_done", 32'(iflush_done), 32'd0);
        chk("reset imemload", imemload, 32'd0);
        @(negedge CLK);
        imemREN = 1'b0;
        nRST    = 1'b1;

        // Cold miss at 0x40, two wait cycles per beat
        cycle(1'b1, 32'h40, 1'b0, 1'b0);
        chk("cold miss ihit", 32'(obs_hit), 32'd0);
        for (int beat = 0; beat < 2; beat++) begin
            for (int k = 0; k < 3; k++) begin
                cycle(1'b1, 32'h40, 1'b0, (k < 2));
                chk("cold iREN", 32'(obs_ren), 32'd1);
                chk("cold iaddr", obs_addr, 32'h40 + 32'(beat * 4));
            end
        end
        cycle(1'b1, 32'h40, 1'b0, 1'b0);
        chk("cold hit 0x40", 32'(obs_hit), 32'd1);
        chk("cold data 0x40", obs_load, 32'hC0DE_0040);
        chk("cold iREN dropped", 32'(obs_ren), 32'd0);
        cycle(1'b1, 32'h44, 1'b0, 1'b0);
        chk("hit 0x44", 32'(obs_hit), 32'd1);
        chk("data 0x44", obs_load, 32'hC0DE_0044);

        // Conflict in set 0: third fill replaces way 0
        fill_to_hit(32'h000);
        fill_to_hit(32'h080);
        fill_to_hit(32'h100);
        cycle(1'b1, 32'h080, 1'b0, 1'b0);
        chk("conflict 0x080 hit", 32'(obs_hit), 32'd1);
        chk("conflict 0x080 data", obs_load, 32'hC0DE_0080);
        cycle(1'b1, 32'h000, 1'b0, 1'b0);
        chk("conflict 0x000 miss", 32'(obs_hit), 32'd0);
        fill_to_hit(32'h000);
        cycle(1'b1, 32'h104, 1'b0, 1'b0);
        chk("conflict 0x104 hit", 32'(obs_hit), 32'd1);

        // Flush in IDLE after filling four sets
        fill_to_hit(32'h010);
        fill_to_hit(32'h018);
        cycle(1'b1, 32'h010, 1'b0, 1'b0);
        chk("pre-flush 0x010 hit", 32'(obs_hit), 32'd1);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        count_flush(n);
        chk("idle flush length", 32'(n), 32'd16);

        // Previously cached 0x40 misses; address moves to 0x200 mid-fill
        cycle(1'b1, 32'h40, 1'b0, 1'b0);
        chk("post-flush 0x40 miss", 32'(obs_hit), 32'd0);
        cycle(1'b1, 32'h200, 1'b0, 1'b0);
        chk("midfill beat0 iaddr", obs_addr, 32'h40);
        cycle(1'b1, 32'h200, 1'b0, 1'b0);
        chk("midfill beat1 iaddr", obs_addr, 32'h44);
        cycle(1'b1, 32'h200, 1'b0, 1'b0);
        chk("midfill gap iREN", 32'(obs_ren), 32'd0);
        chk("midfill gap ihit", 32'(obs_hit), 32'd0);
        cycle(1'b1, 32'h200, 1'b0, 1'b0);
        chk("new fill iaddr", obs_addr, 32'h200);
        fill_to_hit(32'h200);
        cycle(1'b1, 32'h44, 1'b0, 1'b0);
        chk("0x44 after midfill", obs_load, 32'hC0DE_0044);

        // Flush requested during fill beat 0
        cycle(1'b1, 32'h300, 1'b0, 1'b0);
        chk("0x300 miss", 32'(obs_hit), 32'd0);
        cycle(1'b1, 32'h300, 1'b1, 1'b1);
        chk("fill+flush iaddr", obs_addr, 32'h300);
        cycle(1'b1, 32'h300, 1'b0, 1'b0);
        cycle(1'b1, 32'h300, 1'b0, 1'b0);
        chk("fill+flush beat1", obs_addr, 32'h304);
        count_flush(n);
        chk("pending flush length", 32'(n), 32'd16);
        cycle(1'b1, 32'h300, 1'b0, 1'b0);
        chk("0x300 invalid after flush", 32'(obs_hit), 32'd0);
        fill_to_hit(32'h300);

        // Reset after the first beat of a fill
        cycle(1'b1, 32'h500, 1'b0, 1'b0);
        chk("0x500 miss", 32'(obs_hit), 32'd0);
        cycle(1'b1, 32'h500, 1'b0, 1'b0);
        chk("0x500 beat0", obs_addr, 32'h500);
        cycle(1'b1, 32'h500, 1'b0, 1'b1);
        chk("0x500 beat1 iREN", 32'(obs_ren), 32'd1);
        do_reset_mid();
        cycle(1'b1, 32'h500, 1'b0, 1'b0);
        chk("0x500 miss after reset", 32'(obs_hit), 32'd0);
        cycle(1'b1, 32'h500, 1'b0, 1'b1);
        chk("0x500 refetch word0", obs_addr, 32'h500);
        fill_to_hit(32'h500);

        // Randomized traffic over a small address pool
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                a = $urandom();
            end else begin
                a = (32'($urandom_range(0, 5)) << 7) | (32'($urandom_range(0, 3)) << 3)
                  | (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 599) == 0) begin
                do_reset_mid();
            end else begin
                cycle(($urandom_range(0, 3) != 0), a, ($urandom_range(0, 63) == 0),
                      ($urandom_range(0, 2) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
